// File: rtl/mult32_ctrl_pkg.sv
// Shared definitions for the shift-add multiplier controller: state encodings
// and the default operand width.
package mult32_ctrl_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_TEST  = 3'd2,
    S_ADD   = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/mult32_ctrl.sv
// Sequencing FSM for the shift-add multiplier datapath: issues load/add/shift/write
// strobes for WIDTH iterations and reports completion with a one-cycle done pulse.
module mult32_ctrl
  import mult32_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             mplr_lsb,
  output logic             ready,
  output logic             busy,
  output logic             load,
  output logic             add_en,
  output logic             shift_en,
  output logic             write_en,
  output logic             done,
  output logic [CNT_W-1:0] iter_cnt
);

  localparam logic [CNT_W-1:0] LastIter = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ready    = 1'b0;
    busy     = 1'b0;
    load     = 1'b0;
    add_en   = 1'b0;
    shift_en = 1'b0;
    write_en = 1'b0;
    done     = 1'b0;

    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (start && !abort) state_d = S_LOAD;
      end
      S_LOAD: begin
        busy    = 1'b1;
        load    = 1'b1;
        cnt_d   = '0;
        state_d = S_TEST;
      end
      S_TEST: begin
        busy    = 1'b1;
        state_d = mplr_lsb ? S_ADD : S_SHIFT;
      end
      S_ADD: begin
        busy    = 1'b1;
        add_en  = 1'b1;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        busy     = 1'b1;
        shift_en = 1'b1;
        // Explicit wrap keeps iter_cnt at zero after the last iteration for any WIDTH.
        if (cnt_q == LastIter) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_TEST;
        end
      end
      S_DONE: begin
        busy     = 1'b1;
        write_en = 1'b1;
        done     = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  assign iter_cnt = cnt_q;

endmodule

// File: tb/tb_mult32_ctrl.sv
// Bench for mult32_ctrl: models the multiplier datapath (drives mplr_lsb) and
// compares every cycle against an expected strobe trace derived from B's bits.
module tb_mult32_ctrl;

  localparam int W  = 32;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          reset, start, abort, mplr_lsb;
  logic          ready, busy, load, add_en, shift_en, write_en, done;
  logic [CW-1:0] iter_cnt;

  mult32_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .mplr_lsb(mplr_lsb),
    .ready(ready), .busy(busy), .load(load), .add_en(add_en), .shift_en(shift_en),
    .write_en(write_en), .done(done), .iter_cnt(iter_cnt)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFail   = 0;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    nChecks++;
    if (actual != expected) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Expected per-cycle controller behaviour, derived from the multiplier bits.
  typedef struct packed {
    logic          idle;
    logic          load;
    logic          add;
    logic          shift;
    logic          wr;
    logic [CW-1:0] cnt;
  } exp_t;

  function automatic exp_t mk(input logic i, l, a, s, w, input int c);
    exp_t e;
    e.idle = i; e.load = l; e.add = a; e.shift = s; e.wr = w; e.cnt = CW'(c);
    return e;
  endfunction

  exp_t        expQ[$];
  exp_t        cur = '{idle: 1'b1, default: '0};
  logic [31:0] opA = '0, opB = '0;
  int          cyc = 0, absCyc = 0;
  bit          checkOn = 1'b0;

  int          loadCnt = 0, addCnt = 0, shiftCnt = 0, wrCnt = 0, doneCnt = 0;
  int          totalDone = 0, doneCyc = 0, doneAbs = 0;
  logic [63:0] mcand = '0, prod = '0, result = '0;
  logic [31:0] mplr = '0;

  assign mplr_lsb = mplr[0];

  function automatic void buildTrace(input logic [31:0] b);
    expQ.delete();
    expQ.push_back(mk(0, 1, 0, 0, 0, 0));
    for (int i = 0; i < W; i++) begin
      expQ.push_back(mk(0, 0, 0, 0, 0, i));
      if (b[i]) expQ.push_back(mk(0, 0, 1, 0, 0, i));
      expQ.push_back(mk(0, 0, 0, 1, 0, i));
    end
    expQ.push_back(mk(0, 0, 0, 0, 1, 0));
  endfunction

  always @(posedge clk) begin
    absCyc++;
    if (reset) begin
      expQ.delete();
      cur     = mk(1, 0, 0, 0, 0, 0);
      checkOn = 1'b1;
    end else if (!cur.idle) begin
      if (abort) begin
        expQ.delete();
        cur = mk(1, 0, 0, 0, 0, 0);
      end else if (expQ.size() > 0) begin
        cur = expQ.pop_front();
        cyc++;
      end else begin
        cur = mk(1, 0, 0, 0, 0, 0);
      end
    end else if (start && !abort) begin
      buildTrace(opB);
      cur = expQ.pop_front();
      cyc = 1;
      loadCnt = 0; addCnt = 0; shiftCnt = 0; wrCnt = 0; doneCnt = 0;
    end
  end

  // Compare outputs against the expected trace, then advance the datapath model.
  always @(negedge clk) begin
    if (checkOn) begin
      checkOutput("cycleOutputs",
                  {ready, busy, load, add_en, shift_en, write_en, done, iter_cnt},
                  {cur.idle, !cur.idle, cur.load, cur.add, cur.shift, cur.wr, cur.wr, cur.cnt});
      if (load) begin
        mcand = {32'b0, opA}; mplr = opB; prod = '0; loadCnt++;
      end
      if (add_en) begin
        prod = prod + mcand; addCnt++;
      end
      if (shift_en) begin
        mcand = mcand << 1; mplr = mplr >> 1; shiftCnt++;
      end
      if (write_en) begin
        result = prod; wrCnt++;
      end
      if (done) begin
        doneCnt++; totalDone++; doneCyc = cyc; doneAbs = absCyc;
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input bit noise);
    int lat;
    bit got;
    lat = 2 * W + $countones(b) + 2;
    @(posedge clk); #1;
    opA = a; opB = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk); #1;
      if (doneCnt > 0) got = 1'b1;
      else if (noise) start = (cyc < 60) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    start = 1'b0;
    checkOutput("doneSeen", longint'(got), 1);
    checkOutput("doneCycle", doneCyc, lat);
    checkOutput("loadCount", loadCnt, 1);
    checkOutput("addCount", addCnt, $countones(b));
    checkOutput("shiftCount", shiftCnt, W);
    checkOutput("product", result, {32'b0, a} * {32'b0, b});
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int prevDone, dAbs[$];
    logic [31:0] a, b;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk); #1;
    checkOutput("resetReady", ready, 1);
    checkOutput("resetIter", iter_cnt, 0);
    checkOutput("resetStrobes", {busy, load, add_en, shift_en, write_en, done}, 0);

    applyStimulus(32'd3, 32'd2, 1'b0);
    checkOutput("b2Latency", doneCyc, 67);
    checkOutput("b2Adds", addCnt, 1);
    checkOutput("b2Product", result, 6);

    applyStimulus(32'd1234, 32'd0, 1'b0);
    checkOutput("b0Latency", doneCyc, 66);
    checkOutput("b0Adds", addCnt, 0);
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    checkOutput("bOnesLatency", doneCyc, 98);
    checkOutput("bOnesAdds", addCnt, 32);
    checkOutput("bOnesProduct", result, 64'hFFFF_FFFE_0000_0001);
    applyStimulus(32'd15, 32'd4, 1'b0);
    checkOutput("p15x4", result, 60);
    applyStimulus(32'd25, 32'd5, 1'b0);
    checkOutput("p25x5", result, 125);

    // Abort in cycle 20 of a B=5 operation.
    @(posedge clk); #1;
    opA = 32'd7; opB = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 100 && cyc != 20; i++) begin
      @(posedge clk); #1;
    end
    checkOutput("abortReachedCycle20", cyc, 20);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk); #1;
    checkOutput("abortReady", ready, 1);
    checkOutput("abortIter", iter_cnt, 0);
    repeat (80) @(posedge clk);
    #1;
    checkOutput("abortNoDone", doneCnt, 0);
    checkOutput("abortNoWrite", wrCnt, 0);

    // Reset while in ADD (cycle 3 when B bit 0 is set).
    @(posedge clk); #1;
    opA = 32'd11; opB = 32'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 20 && cyc != 3; i++) begin
      @(posedge clk); #1;
    end
    checkOutput("resetAddInAdd", add_en, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk); #1;
    checkOutput("resetAddReady", ready, 1);
    checkOutput("resetAddStrobes", {busy, load, add_en, shift_en, write_en, done, iter_cnt}, 0);
    applyStimulus(32'd9, 32'd3, 1'b0);
    checkOutput("afterResetProduct", result, 27);

    // Start held high across three operations, with one extra pulse mid-operation.
    @(posedge clk); #1;
    opA = $urandom; opB = $urandom;
    start = 1'b1;
    prevDone = totalDone;
    for (int i = 0; i < 600 && (totalDone - prevDone) < 3; i++) begin
      @(negedge clk); #1;
      if (totalDone - prevDone > dAbs.size()) dAbs.push_back(doneAbs);
      start = (cyc != 10);
    end
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("heldDoneCount", totalDone - prevDone, 3);
    if (dAbs.size() == 3) begin
      checkOutput("heldGap1", dAbs[1] - dAbs[0], 2 * W + $countones(opB) + 3);
      checkOutput("heldGap2", dAbs[2] - dAbs[1], 2 * W + $countones(opB) + 3);
    end
    checkOutput("heldProduct", result, {32'b0, opA} * {32'b0, opB});
    prevDone = totalDone;
    repeat (150) @(posedge clk);
    #1;
    checkOutput("heldNoExtraOp", totalDone - prevDone, 0);

    // Randomized operations with stray start pulses while busy.
    for (int n = 0; n < 12; n++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom & $urandom;
        1: b = $urandom | $urandom;
        2: b = 32'h1 << $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      applyStimulus(a, b, 1'b1);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
